bs_encoder: RTL and testbench
=============================

BS_ENCODER -- requirements
Module: bs_encoder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on posedge clk.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port abort, input, 1, synchronous return to IDLE from protocolFSM.
REQ-004 SHALL have port start_encode, input, 1, one-cycle request from protocolFSM; sampled in IDLE only.
REQ-005 SHALL have port pkt_type, input, 2, 2'b11 DATA (PID + payload), 2'b10 HSHAKE (PID only), others illegal.
REQ-006 SHALL have port pid, input, 4, PID nibble, latched with start_encode.
REQ-007 SHALL have port byte_in, input, 8, payload byte from data source.
REQ-008 SHALL have port byte_valid, input, 1, byte_in and last_byte are valid.
REQ-009 SHALL have port last_byte, input, 1, byte_in is the final payload byte.
REQ-010 SHALL have port byte_ready, output, 1, byte_in accepted this cycle.
REQ-011 SHALL have port stuff_stall, input, 1, bit stuffer inserting a bit; hold the current bit.
REQ-012 SHALL have ports s_out and s_valid, output, 1 each, serial bit to the bit stuffer and CRC generator.
REQ-013 SHALL have ports start_crc and end_crc, output, 1 each, CRC generator framing pulses.
REQ-014 SHALL have ports encoder_busy, encode_done, enc_error and pid_error, output, 1 each, status to protocolFSM.

Function
REQ-015 SHALL implement the states IDLE, SYNC, PID, DATA and DONE.
REQ-016 IDLE: start_encode with legal pkt_type SHALL latch pid/pkt_type and go to SYNC; illegal pkt_type SHALL be ignored.
REQ-017 SYNC SHALL emit 0,0,0,0,0,0,0,1 in that order, one bit per non-stalled cycle, first bit on the cycle after start_encode.
REQ-018 PID SHALL emit pid[0..3] then ~pid[0..3].
REQ-019 Leaving PID: HSHAKE SHALL go to DONE; DATA SHALL go to DATA.
REQ-020 DATA SHALL emit each byte LSB first; start_crc SHALL pulse with the first payload bit only.
REQ-021 Byte load SHALL occur on the cycle the last bit of PID or of the previous byte is accepted; byte_ready pulses then, and bit0 goes out next cycle.
REQ-022 If byte_valid is low at a load point, SHALL pulse enc_error, drop s_valid and go to IDLE (underrun); no end_crc or encode_done.
REQ-023 After the last bit of a last_byte byte, SHALL enter DONE; end_crc SHALL pulse in DONE for DATA only.
REQ-024 DONE SHALL pulse encode_done for one cycle and then go to IDLE; DONE is not gated by stuff_stall.
REQ-025 stuff_stall high SHALL freeze s_out, the bit counter and the state, with s_valid held high; stuff_stall in IDLE/DONE SHALL be ignored.
REQ-026 s_valid SHALL be high exactly during SYNC/PID/DATA bit cycles; s_out SHALL be 0 when s_valid is low.
REQ-027 encoder_busy SHALL be high in every state except IDLE; start_encode while busy SHALL be ignored.
REQ-028 HSHAKE latency with no stall: start at cycle 0, bits at cycles 1-16, encode_done at cycle 17.
REQ-029 abort SHALL take priority over all transitions: IDLE next cycle, all pulses suppressed.

Reset
REQ-030 rst SHALL force IDLE; all outputs 0; counters and shift register cleared; rst has priority over abort.
REQ-031 rst mid-packet SHALL behave as abort, with no encode_done, end_crc or enc_error.

Configuration
REQ-032 Macro BS_ENC_PID_CHECK_EN defined: start_encode with pid[1:0] != pkt_type SHALL pulse pid_error, remain in IDLE and emit nothing.
REQ-033 Macro BS_ENC_PID_CHECK_EN undefined: no check; pid_error tied 0.

Structure
REQ-034 Package usb_pkg SHALL hold the pkt_type enum (NONE/DATA/HSHAKE), the SYNC pattern constant and the encoder state enum.
REQ-035 Sub-module piso_shifter SHALL provide the 8-bit parallel load, LSB-first shift and 3-bit count with a hold input.

Verification
REQ-036 HSHAKE, pid=4'b0010 -> bits 00000001, 0100, 1011; encode_done at cycle 17; no start_crc or end_crc.
REQ-037 DATA, pid=4'b0011, bytes 8'hA5 then 8'h3C (last) -> payload 10100101 00111100; start_crc with first payload bit; end_crc and encode_done in DONE.
REQ-038 Two-cycle stuff_stall during SYNC bit 3 -> that bit held for 3 cycles; encode_done delayed by 2.
REQ-039 byte_valid low at the second byte load -> enc_error pulse, s_valid 0, IDLE; no end_crc.
REQ-040 abort during DATA, and rst during PID -> IDLE next cycle, all outputs 0; a new start_encode is accepted afterwards.
REQ-041 With BS_ENC_PID_CHECK_EN, DATA with pid=4'b0010 -> pid_error pulse, s_valid never high.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared encoder types: packet kinds, the SYNC pattern and the encoder FSM states.
package usb_pkg;

    typedef enum logic [1:0] {
        PktNone   = 2'b00,
        PktHshake = 2'b10,
        PktData   = 2'b11
    } pkt_type_e;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StPid,
        StData,
        StDone
    } enc_state_e;

    // Shifted out LSB first: seven zeros followed by a one.
    localparam logic [7:0] SyncPattern = 8'b1000_0000;

    function automatic logic is_legal_pkt(input logic [1:0] t);
        return (t == PktData) || (t == PktHshake);
    endfunction

endpackage

// File: rtl/piso_shifter.sv
// 8-bit parallel-in serial-out shifter, LSB first, with a bit counter and a hold input.
module piso_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic       i_hold,
    input  logic [7:0] i_data,
    output logic       o_bit,
    output logic [2:0] o_count
);

    logic [7:0] r_shift;
    logic [2:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_count <= '0;
        end else if (!i_hold) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_count <= r_count + 3'd1;
        end
    end

    assign o_bit   = r_shift[0];
    assign o_count = r_count;

endmodule

// File: rtl/bs_encoder.sv
// Bit-serial packet encoder: SYNC, PID and LSB-first payload towards the bit stuffer and CRC.
// Define BS_ENC_PID_CHECK_EN to reject requests whose pid[1:0] disagrees with pkt_type.
module bs_encoder
    import usb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       abort,
    input  logic       start_encode,
    input  logic [1:0] pkt_type,
    input  logic [3:0] pid,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       last_byte,
    output logic       byte_ready,
    input  logic       stuff_stall,
    output logic       s_out,
    output logic       s_valid,
    output logic       start_crc,
    output logic       end_crc,
    output logic       encoder_busy,
    output logic       encode_done,
    output logic       enc_error,
    output logic       pid_error
);

    enc_state_e r_state;
    enc_state_e w_state_next;
    logic [3:0] r_pid;
    pkt_type_e  r_type;
    logic       r_last;
    logic       r_first;

    logic       w_legal;
    logic       w_pid_err;
    logic       w_accept;
    logic       w_bit_state;
    logic       w_bit_done;
    logic       w_load_byte;
    logic       w_underrun;
    logic       w_sh_clear;
    logic       w_sh_load;
    logic       w_sh_hold;
    logic       w_sh_bit;
    logic [7:0] w_sh_data;
    logic [2:0] w_sh_count;

    assign w_legal = is_legal_pkt(pkt_type);

`ifdef BS_ENC_PID_CHECK_EN
    assign w_pid_err = (r_state == StIdle) && start_encode && w_legal &&
                       (pid[1:0] != pkt_type);
`else
    assign w_pid_err = 1'b0;
`endif

    assign w_accept    = (r_state == StIdle) && start_encode && w_legal && !w_pid_err;
    assign w_bit_state = (r_state == StSync) || (r_state == StPid) || (r_state == StData);
    assign w_bit_done  = w_bit_state && !stuff_stall && (w_sh_count == 3'd7);
    // A byte is fetched as the final bit of the PID or of a non-final byte goes out.
    assign w_load_byte = w_bit_done && (((r_state == StPid) && (r_type == PktData)) ||
                                        ((r_state == StData) && !r_last));
    assign w_underrun  = w_load_byte && !byte_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: if (w_accept) w_state_next = StSync;
                StSync: if (w_bit_done) w_state_next = StPid;
                StPid: begin
                    if (w_bit_done) begin
                        if (r_type != PktData) w_state_next = StDone;
                        else if (byte_valid)   w_state_next = StData;
                        else                   w_state_next = StIdle;
                    end
                end
                StData: begin
                    if (w_bit_done) begin
                        if (r_last)          w_state_next = StDone;
                        else if (byte_valid) w_state_next = StData;
                        else                 w_state_next = StIdle;
                    end
                end
                StDone:  w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pid   <= '0;
            r_type  <= PktNone;
            r_last  <= 1'b0;
            r_first <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pid   <= pid;
                r_type  <= pkt_type_e'(pkt_type);
                r_last  <= 1'b0;
                r_first <= 1'b1;
            end else if (r_state == StData) begin
                r_first <= 1'b0;
            end
            if (w_load_byte && byte_valid) begin
                r_last <= last_byte;
            end
        end
    end

    assign w_sh_clear = abort || (w_state_next == StIdle);
    assign w_sh_load  = !abort && (w_accept || ((r_state == StSync) && w_bit_done) ||
                                   (w_load_byte && byte_valid));
    assign w_sh_hold  = !w_bit_state || stuff_stall;
    assign w_sh_data  = (r_state == StIdle) ? SyncPattern :
                        (r_state == StSync) ? {~r_pid, r_pid} : byte_in;

    piso_shifter u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_sh_clear),
        .i_load  (w_sh_load),
        .i_hold  (w_sh_hold),
        .i_data  (w_sh_data),
        .o_bit   (w_sh_bit),
        .o_count (w_sh_count)
    );

    always_comb begin
        s_valid      = 1'b0;
        s_out        = 1'b0;
        encoder_busy = 1'b0;
        byte_ready   = 1'b0;
        enc_error    = 1'b0;
        start_crc    = 1'b0;
        end_crc      = 1'b0;
        encode_done  = 1'b0;
        pid_error    = 1'b0;
        if (!rst) begin
            s_valid      = w_bit_state;
            s_out        = w_bit_state && w_sh_bit;
            encoder_busy = (r_state != StIdle);
            if (!abort) begin
                byte_ready  = w_load_byte && byte_valid;
                enc_error   = w_underrun;
                start_crc   = (r_state == StData) && r_first;
                end_crc     = (r_state == StDone) && (r_type == PktData);
                encode_done = (r_state == StDone);
                pid_error   = w_pid_err;
            end
        end
    end

endmodule

// File: tb/tb_bs_encoder.sv
// Randomised self-checking bench for bs_encoder against a bit-list reference model.
module tb_bs_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       abort;
    logic       start_encode;
    logic [1:0] pkt_type;
    logic [3:0] pid;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       last_byte;
    logic       byte_ready;
    logic       stuff_stall;
    logic       s_out;
    logic       s_valid;
    logic       start_crc;
    logic       end_crc;
    logic       encoder_busy;
    logic       encode_done;
    logic       enc_error;
    logic       pid_error;

    int         n_tests = 0;
    int         n_fail = 0;
    int         done_cyc;
    logic [7:0] tx_bytes [8];

    always #5 clk = ~clk;

    bs_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .abort        (abort),
        .start_encode (start_encode),
        .pkt_type     (pkt_type),
        .pid          (pid),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .last_byte    (last_byte),
        .byte_ready   (byte_ready),
        .stuff_stall  (stuff_stall),
        .s_out        (s_out),
        .s_valid      (s_valid),
        .start_crc    (start_crc),
        .end_crc      (end_crc),
        .encoder_busy (encoder_busy),
        .encode_done  (encode_done),
        .enc_error    (enc_error),
        .pid_error    (pid_error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk(tag, {23'd0, s_valid, s_out, byte_ready, start_crc, end_crc, encoder_busy,
                  encode_done, enc_error, pid_error}, 32'd0);
    endtask

    // Runs one packet in lockstep with a model that walks the expected bit list.
    task automatic run_pkt(input logic [1:0] ty, input logic [3:0] p, input int nbytes,
                           input int under_at, input int kill_at, input bit kill_rst,
                           input int stall_mode);
        logic       exp_bits[$];
        logic [7:0] b;
        int         k = 0;
        int         j = 0;
        int         cyc;
        int         nd;
        int         jl;
        int         dstall = 0;
        int         total;
        bit         is_data;
        bit         crc_seen = 0;
        bit         fin = 0;
        bit         stl;
        bit         ld;

        is_data = (ty == 2'b11);
        for (int i = 0; i < 7; i++) exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1);
        for (int i = 0; i < 4; i++) exp_bits.push_back(p[i]);
        for (int i = 0; i < 4; i++) exp_bits.push_back(~p[i]);
        nd = !is_data ? 0 : (under_at >= 0) ? under_at : nbytes;
        for (int jj = 0; jj < nd; jj++) begin
            b = tx_bytes[jj];
            for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        end
        total = exp_bits.size();
        done_cyc = -1;

        start_encode = 1'b1;
        pkt_type     = ty;
        pid          = p;
        abort        = 1'b0;
        rst          = 1'b0;
        stuff_stall  = 1'($urandom);
        byte_in      = tx_bytes[0];
        byte_valid   = (under_at != 0);
        last_byte    = (nbytes == 1);
        @(negedge clk);
        check_idle("start_cycle");
        @(posedge clk);
        #1;
        cyc = 1;
        while (!fin && cyc < 400) begin
            start_encode = ($urandom_range(0, 3) == 0);
            pkt_type     = 2'($urandom);
            pid          = 4'($urandom);
            case (stall_mode)
                1:       stl = ($urandom_range(0, 4) == 0);
                2:       stl = (k == 3) && (dstall < 2);
                default: stl = 1'b0;
            endcase
            if (stall_mode == 2 && stl) dstall++;
            stuff_stall = stl;
            abort       = (cyc == kill_at) && !kill_rst;
            rst         = (cyc == kill_at) && kill_rst;
            if (is_data && j < nbytes) begin
                byte_in    = tx_bytes[j];
                byte_valid = (j != under_at);
                last_byte  = (j == nbytes - 1);
            end else begin
                byte_in    = 8'($urandom);
                byte_valid = 1'($urandom);
                last_byte  = 1'($urandom);
            end
            @(negedge clk);
            if (cyc == kill_at) begin
                if (kill_rst) check_idle("rst_cycle");
                else chk("abort_pulses", {27'd0, byte_ready, start_crc, end_crc, encode_done,
                                          enc_error}, 32'd0);
                fin = 1;
            end else if (k < total) begin
                chk("s_valid", 32'(s_valid), 32'd1);
                chk("s_out", 32'(s_out), 32'(exp_bits[k]));
                chk("busy", 32'(encoder_busy), 32'd1);
                chk("start_crc", 32'(start_crc), 32'(is_data && k == 16 && !crc_seen));
                if (k == 16) crc_seen = 1;
                jl = (k - 15) / 8;
                ld = is_data && !stl && k >= 15 && ((k - 15) % 8 == 0) && jl < nbytes;
                chk("byte_ready", 32'(byte_ready), 32'(ld && jl != under_at));
                chk("enc_error", 32'(enc_error), 32'(ld && jl == under_at));
                chk("early_done", {30'd0, encode_done, end_crc}, 32'd0);
                if (ld && jl != under_at) j++;
                if (ld && jl == under_at) fin = 1;
                if (!stl) k++;
            end else begin
                chk("encode_done", 32'(encode_done), 32'd1);
                chk("end_crc", 32'(end_crc), 32'(is_data));
                chk("s_valid_done", 32'(s_valid), 32'd0);
                chk("busy_done", 32'(encoder_busy), 32'd1);
                done_cyc = cyc;
                fin = 1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
        start_encode = 1'b0;
        abort        = 1'b0;
        rst          = 1'b0;
        stuff_stall  = 1'($urandom);
        @(negedge clk);
        check_idle("post_idle");
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        abort        = 1'b0;
        start_encode = 1'b0;
        pkt_type     = 2'b00;
        pid          = 4'h0;
        byte_in      = 8'h00;
        byte_valid   = 1'b0;
        last_byte    = 1'b0;
        stuff_stall  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle("reset");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_pkt(2'b10, 4'b0010, 0, -1, -1, 1'b0, 0);
        chk("hshake_latency", 32'(done_cyc), 32'd17);

        tx_bytes[0] = 8'hA5;
        tx_bytes[1] = 8'h3C;
        run_pkt(2'b11, 4'b0011, 2, -1, -1, 1'b0, 0);
        chk("data_latency", 32'(done_cyc), 32'd33);

        run_pkt(2'b10, 4'b0010, 0, -1, -1, 1'b0, 2);
        chk("stall_latency", 32'(done_cyc), 32'd19);

        run_pkt(2'b11, 4'b1011, 3, 1, -1, 1'b0, 0);
        run_pkt(2'b11, 4'b0011, 2, -1, 20, 1'b0, 0);
        run_pkt(2'b11, 4'b0011, 2, -1, 12, 1'b1, 0);
        run_pkt(2'b10, 4'b0010, 0, -1, -1, 1'b0, 1);

        start_encode = 1'b1;
        pkt_type     = 2'b01;
        pid          = 4'b0001;
        @(negedge clk);
        check_idle("illegal_01");
        @(posedge clk);
        #1;
        pkt_type = 2'b00;
        pid      = 4'b0000;
        @(negedge clk);
        check_idle("illegal_00");
        @(posedge clk);
        #1;
        start_encode = 1'b0;
        @(negedge clk);
        check_idle("illegal_after");
        @(posedge clk);
        #1;

`ifdef BS_ENC_PID_CHECK_EN
        start_encode = 1'b1;
        pkt_type     = 2'b11;
        pid          = 4'b0010;
        @(negedge clk);
        chk("pid_error", 32'(pid_error), 32'd1);
        chk("pid_err_sval", 32'(s_valid), 32'd0);
        @(posedge clk);
        #1;
        start_encode = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("pid_err_idle");
            @(posedge clk);
            #1;
        end
`endif

        for (int n = 0; n < 40; n++) begin
            logic [1:0] ty;
            int         nb;
            int         ua;
            int         ka;
            ty = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
            nb = $urandom_range(1, 6);
            for (int i = 0; i < 8; i++) tx_bytes[i] = 8'($urandom);
            ua = -1;
            ka = -1;
            case ($urandom_range(0, 5))
                0:       if (ty == 2'b11) ua = $urandom_range(0, nb - 1);
                1:       ka = $urandom_range(1, 17);
                default: ;
            endcase
            run_pkt(ty, {2'($urandom), ty}, nb, ua, ka, 1'($urandom), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
